// File: rtl/user_keys_ctrl.sv
// User key block: 2-FF synchroniser, per-key debouncer, sticky press flags, maskable level IRQ.
// Define USER_KEYS_RELEASE_EDGE_EN to add sticky release-edge flags in word 3.
module user_keys_ctrl #(
    parameter int N_KEYS       = 8,
    parameter int ACTIVE_LOW   = 1,
    parameter int TICK_DIV     = 20000,
    parameter int STABLE_TICKS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        Addr,
    input  logic              WE,
    input  logic [31:0]       Din,
    output logic [31:0]       Dout,
    output logic              IRQ,
    input  logic [N_KEYS-1:0] user_key
);
    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0]     presc_reg;
    logic              tick;
    logic [N_KEYS-1:0] pin_level;
    logic [N_KEYS-1:0] sync1_reg;
    logic [N_KEYS-1:0] sync2_reg;
    logic [N_KEYS-1:0] deb_reg;
    logic [N_KEYS-1:0] deb_d_reg;
    logic [N_KEYS-1:0] accept;
    logic [N_KEYS-1:0] rise;
    logic [N_KEYS-1:0] status_reg;
    logic [N_KEYS-1:0] mask_reg;
    logic [N_KEYS-1:0] irq_src;
    logic [N_KEYS-1:0] w1c_status;
    logic              unused_bits;

    // Polarity is folded in ahead of the first flop so everything downstream sees 1 = pressed.
    assign pin_level = (ACTIVE_LOW != 0) ? ~user_key : user_key;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= pin_level;
            sync2_reg <= sync1_reg;
        end
    end

    assign tick = (presc_reg == PW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + PW'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_key
            logic [3:0] cnt_reg;
            logic       diff;

            assign diff       = sync2_reg[gi] ^ deb_reg[gi];
            assign accept[gi] = tick && diff && (cnt_reg == 4'(STABLE_TICKS - 1));

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (tick) begin
                    if (!diff || accept[gi]) begin
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
            end
        end
    endgenerate

    // An accepted key always flips to the synchronised level, so a toggle is enough.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_reg   <= '0;
            deb_d_reg <= '0;
        end else begin
            deb_reg   <= deb_reg ^ accept;
            deb_d_reg <= deb_reg;
        end
    end

    assign rise       = deb_reg & ~deb_d_reg;
    assign w1c_status = (WE && Addr[3:2] == 2'd1) ? Din[N_KEYS-1:0] : '0;

    // Set is OR-ed after the clear so a same-cycle press survives a W1C.
    always_ff @(posedge clk) begin
        if (reset) begin
            status_reg <= '0;
            mask_reg   <= '0;
        end else begin
            status_reg <= (status_reg & ~w1c_status) | rise;
            if (WE && Addr[3:2] == 2'd2) begin
                mask_reg <= Din[N_KEYS-1:0];
            end
        end
    end

`ifdef USER_KEYS_RELEASE_EDGE_EN
    logic [N_KEYS-1:0] fall;
    logic [N_KEYS-1:0] w1c_release;
    logic [N_KEYS-1:0] release_reg;

    assign fall        = ~deb_reg & deb_d_reg;
    assign w1c_release = (WE && Addr[3:2] == 2'd3) ? Din[N_KEYS-1:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            release_reg <= '0;
        end else begin
            release_reg <= (release_reg & ~w1c_release) | fall;
        end
    end

    assign irq_src = status_reg | release_reg;
`else
    assign irq_src = status_reg;
`endif

    assign IRQ = |(irq_src & mask_reg);

    always_comb begin
        Dout = '0;
        case (Addr[3:2])
            2'd0:    Dout = 32'(deb_reg);
            2'd1:    Dout = 32'(status_reg);
            2'd2:    Dout = 32'(mask_reg);
            default: begin
`ifdef USER_KEYS_RELEASE_EDGE_EN
                Dout = 32'(release_reg);
`else
                Dout = '0;
`endif
            end
        endcase
    end

    assign unused_bits = ^{Addr[1:0], Din};

endmodule

// File: tb/tb_user_keys_ctrl.sv
// Self-checking bench for user_keys_ctrl (TICK_DIV=4, STABLE_TICKS=3, ACTIVE_LOW=1).
// Expected values are queued as stimulus is applied and popped when the DUT output is sampled.
module tb_user_keys_ctrl;
    localparam int N_KEYS       = 8;
    localparam int TICK_DIV     = 4;
    localparam int STABLE_TICKS = 3;
`ifdef USER_KEYS_RELEASE_EDGE_EN
    localparam logic [31:0] REL_EXP = 32'h80;
`else
    localparam logic [31:0] REL_EXP = 32'h00;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [3:0]        Addr = '0;
    logic              WE = 1'b0;
    logic [31:0]       Din = '0;
    logic [31:0]       Dout;
    logic              IRQ;
    logic [N_KEYS-1:0] user_key = '1;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] exp_q[$];
    int          n;

    always #5 clk = ~clk;

    user_keys_ctrl #(
        .N_KEYS      (N_KEYS),
        .ACTIVE_LOW  (1),
        .TICK_DIV    (TICK_DIV),
        .STABLE_TICKS(STABLE_TICKS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .Addr    (Addr),
        .WE      (WE),
        .Din     (Din),
        .Dout    (Dout),
        .IRQ     (IRQ),
        .user_key(user_key)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic expect_word(input int w, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        Addr = 4'(w * 4);
        #1;
        check(tag, Dout, exp_q.pop_front());
    endtask

    task automatic expect_irq(input logic exp, input string tag);
        exp_q.push_back({31'b0, exp});
        #1;
        check(tag, {31'b0, IRQ}, exp_q.pop_front());
    endtask

    task automatic wr(input int w, input logic [31:0] data);
        WE   = 1'b1;
        Addr = 4'(w * 4);
        Din  = data;
        @(negedge clk);
        WE   = 1'b0;
        Din  = '0;
    endtask

    // Returns the number of rising edges until word w has any bit of m set, or -1.
    task automatic wait_bit(input int w, input logic [31:0] m, input int budget, output int cnt);
        bit hit;
        hit = 1'b0;
        cnt = -1;
        for (int i = 1; i <= budget && !hit; i++) begin
            @(negedge clk);
            Addr = 4'(w * 4);
            #1;
            if ((Dout & m) != 0) begin
                cnt = i;
                hit = 1'b1;
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset and readback
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        expect_word(0, 32'h0, "rst_state");
        expect_word(1, 32'h0, "rst_status");
        cyc(1);
        expect_word(2, 32'h0, "rst_mask");
        expect_word(3, 32'h0, "rst_word3");
        cyc(1);
        expect_irq(1'b0, "rst_irq");

        // Debounce accept on key 2
        cyc(1);
        wr(2, 32'h04);
        expect_word(2, 32'h04, "mask_write");
        cyc(1);
        user_key[2] = 1'b0;
        wait_bit(0, 32'h04, 20, n);
        if (n < 0) check("accept_timeout", 32'h0, 32'h04);
        else       check("accept_latency_le_14", 32'(n <= 14), 32'h1);
        expect_word(0, 32'h04, "state_accept");
        expect_word(1, 32'h00, "status_one_cycle_lag");
        cyc(1);
        expect_word(1, 32'h04, "status_press");
        expect_irq(1'b1, "irq_press");

        // W1C on a two-bit status
        user_key[0] = 1'b0;
        wait_bit(0, 32'h01, 20, n);
        if (n < 0) check("key0_timeout", 32'h0, 32'h01);
        cyc(2);
        expect_word(1, 32'h05, "status_two_keys");
        cyc(1);
        wr(1, 32'h01);
        expect_word(1, 32'h04, "w1c_bit0");
        expect_irq(1'b1, "irq_mask4");
        cyc(1);
        wr(2, 32'h01);
        expect_irq(1'b0, "irq_mask1");
        cyc(1);
        wr(2, 32'h1FF);
        expect_word(2, 32'hFF, "mask_upper_bits");
        cyc(1);
        wr(2, 32'h0);
        wr(1, 32'hFFFFFFFF);
        expect_word(1, 32'h0, "w1c_all");

        // Release both keys; release flags (if present) are cleared
        user_key = '1;
        cyc(25);
        expect_word(0, 32'h0, "state_released");
        expect_word(1, 32'h0, "status_not_set_by_release");
        cyc(1);
        wr(3, 32'hFF);
        expect_word(3, 32'h0, "word3_cleared");
        expect_irq(1'b0, "irq_idle");

        // Bounce rejection on key 0: 5-cycle half-periods never span three ticks
        for (int i = 0; i < 12; i++) begin
            user_key[0] = (i % 2 == 1);
            cyc(5);
            expect_word(0, 32'h0, "bounce_state");
        end
        user_key[0] = 1'b1;
        cyc(20);
        expect_word(0, 32'h0, "bounce_state_final");
        expect_word(1, 32'h0, "bounce_status_final");

        // Collision: W1C of bit 2 in the cycle its press is latched
        cyc(1);
        user_key[2] = 1'b0;
        wait_bit(0, 32'h04, 20, n);
        if (n < 0) check("collision_timeout", 32'h0, 32'h04);
        WE   = 1'b1;
        Addr = 4'h4;
        Din  = 32'h04;
        cyc(1);
        WE  = 1'b0;
        Din = '0;
        expect_word(1, 32'h04, "collision_set_wins");
        cyc(1);
        wr(1, 32'h04);
        cyc(30);
        expect_word(1, 32'h0, "held_no_reset");
        expect_word(0, 32'h04, "held_state");

        // Reset while key 1 is mid-debounce
        user_key = '1;
        cyc(25);
        user_key[1] = 1'b0;
        cyc(9);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        expect_word(0, 32'h0, "state_after_reset");
        expect_word(2, 32'h0, "mask_after_reset");
        cyc(11);
        expect_word(0, 32'h0, "state_before_window");
        cyc(1);
        expect_word(0, 32'h02, "state_full_window");
        expect_word(1, 32'h0, "status_lag_after_reset");
        cyc(1);
        expect_word(1, 32'h02, "status_after_reset");
        expect_irq(1'b0, "irq_mask_zero");

        // Press and release key 7 with MASK=0x80
        cyc(1);
        wr(2, 32'h80);
        user_key[7] = 1'b0;
        wait_bit(0, 32'h80, 20, n);
        if (n < 0) check("key7_timeout", 32'h0, 32'h80);
        cyc(2);
        user_key[7] = 1'b1;
        cyc(20);
        expect_word(0, 32'h02, "state_key7_released");
        expect_word(3, REL_EXP, "release_word");
        expect_irq(1'b1, "irq_key7");
        cyc(1);
        wr(0, 32'hFFFFFFFF);
        expect_word(0, 32'h02, "state_read_only");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
